operand_scoreboard: RTL
=======================

# operand_scoreboard

Parametrised operand-fetch and hazard unit for the decode stage of the pipelined core. It replaces fixed three-stage forwarding and blanket load stalling with per-register pending-write tracking, an N-port forwarding mux, and an exact stall decision driven by each producer's result latency. It sits between the register-file read ports and the decode/execute pipeline register. It supports single-cycle ALU ops, load-use, and multi-cycle units.

## Interface
Parameters:
- NREG, 32, architectural register count; register 0 is hard-wired zero.
- AW, 5, register-address width; clog2(NREG).
- XLEN, 64, data width.
- NFWD, 3, number of forwarding ports; index 0 is the youngest stage.
- LW, 3, width of the latency field and the per-register countdown.

Ports:
- clk  in  1  clock, rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- iss_valid  in  1  decode holds a valid instruction.
- iss_ra1, iss_ra2  in  AW  source register addresses.
- iss_use1, iss_use2  in  1  source actually read by the instruction.
- iss_wa  in  AW  destination register.
- iss_wen  in  1  instruction writes iss_wa.
- iss_lat  in  LW  cycles beyond one until the result appears on a forwarding port.
- flush  in  1  kill the instruction currently in decode.
- rd1, rd2  in  XLEN  register-file read data for iss_ra1 and iss_ra2.
- fwd_en  in  NFWD  forwarding port valid.
- fwd_wa  in  NFWD*AW  forwarding destination addresses.
- fwd_data  in  NFWD*XLEN  forwarding results.
- wb_valid  in  1  writeback commits this cycle.
- wb_wa  in  AW  writeback destination.
- srca, srcb  out  XLEN  resolved operands.
- stall  out  1  hold fetch and decode; insert a bubble downstream.
- issued  out  1  the instruction leaves decode this cycle.

## Operation
- Per register r (1..NREG-1), the block holds a busy bit and a cnt[LW] countdown. Register 0 is never busy.
- Operand select, applied per source independently, in priority order:
  - The lowest-index port p with fwd_en[p] set and fwd_wa[p] equal to the source (source nonzero) supplies the value.
  - Otherwise the register-file data (rd1 or rd2) is used.
  - A source address of 0 yields 0.
- Source k is blocked when all of the following hold: use_k, ra_k != 0, busy[ra_k], and either cnt[ra_k] != 0 or no forwarding port matches ra_k.
- stall = iss_valid & !flush & (blocked1 | blocked2 | waw).
- issued = iss_valid & !flush & !stall.
- On issued with iss_wen and iss_wa != 0: set busy[iss_wa] and load cnt[iss_wa] from iss_lat.
- At every clock edge, every other busy entry with cnt != 0 decrements by 1, saturating at 0.
- On wb_valid with wb_wa != 0: clear busy[wb_wa], unless the same register is reloaded by an issue in the same cycle. The issue wins.
- Flush does not clear the scoreboard. Older in-flight producers still complete.
- waw is 0 unless the configuration macro below is defined.

## Timing
- srca, srcb, stall and issued are combinational from the inputs and the current scoreboard state. There is no output register.
- Scoreboard updates happen at the rising edge.
- Example: a producer issued in cycle t with iss_lat=L has cnt=L in cycle t+1, L-1 in cycle t+2, and 0 in cycle t+L+1. A dependent instruction is therefore held through cycle t+L and may issue in t+L+1 via forwarding.
- L=0 means back-to-back issue with no stall (ALU op). L=1 is the load-use case: one bubble.
- While stalled, the instruction is re-evaluated every cycle and the scoreboard continues to count down.
- Reset (resetn low, asynchronous) clears all busy bits and counters. stall=0 and issued=iss_valid&!flush while reset is held.
- Deassertion of reset mid-operation loses all pending state. The pipeline must be flushed alongside reset.

## Configuration
- SCOREBOARD_WAW_EN defined:
  - waw = issuing iss_wen to a busy iss_wa whose cnt > iss_lat.
  - This prevents a younger fast write from being overtaken by an older slow one (for example, a divide followed by an addi to the same register).
- SCOREBOARD_WAW_EN undefined:
  - waw = 0.
  - The issue simply overwrites the entry.
  - Writebacks are in order by construction.

## Test plan
- Back-to-back: issue addi x5 (lat 0) in cycle 1, then add x6,x5,x5 in cycle 2 with fwd port 0 = {x5, 0x2A} -> stall=0, srca=srcb=0x2A.
- Load-use: ld x7 (lat 1), then use x7 next cycle -> stall=1 for exactly 1 cycle. The following cycle fwd port 1 = {x7, 0xDEAD} gives srca=0xDEAD and issued=1.
- Priority: x3 matches port 0 (0x11) and port 2 (0x33) simultaneously, and rd1=0x99 -> srca=0x11. Source x0 with port 0 = {x0, 0xFF} -> srca=0.
- Writeback vs issue: wb_valid on x9 in the same cycle as an issue writing x9 with lat 4 -> busy[x9]=1. A consumer of x9 stalls for the next 4 cycles.
- Flush: with the consumer stalled on x4, assert flush -> stall=0, issued=0, and the scoreboard is unchanged. The x4 producer still completes and its writeback clears busy.
- WAW (macro on): div x8 (lat 5), then addi x8 (lat 0) -> stall until cnt[x8]=0. With the macro off -> issued=1 immediately.

Source files
------------

// File: rtl/operand_scoreboard.sv
// -----------------------------------------------------------------------------
// operand_scoreboard
//
// Operand-fetch and hazard unit for the decode stage. Each architectural
// register has a pending-write (busy) bit and a countdown of the cycles left
// until its producer's result shows up on a forwarding port. Each source
// operand is resolved from the youngest matching forwarding port, or else
// from the register file. Decode stalls only when the needed value cannot be
// supplied this cycle.
//
// Optional feature: define SCOREBOARD_WAW_EN to hold an instruction that
// would write a busy register sooner than the in-flight producer. This stops
// an older slow write from landing after a younger fast one. When the macro
// is undefined, a new issue simply overwrites the scoreboard entry.
//
// Ports:
//   clk, resetn          rising-edge clock, asynchronous active-low reset
//   iss_valid            decode holds a valid instruction
//   iss_ra1/iss_ra2      source register addresses
//   iss_use1/iss_use2    source actually read
//   iss_wa/iss_wen       destination register / write enable
//   iss_lat              result latency beyond one cycle
//   flush                kill the instruction in decode
//   rd1/rd2              register-file read data
//   fwd_en/fwd_wa/       forwarding ports (port 0 = youngest stage)
//   fwd_data
//   wb_valid/wb_wa       writeback commit
//   srca/srcb            resolved operands
//   stall                hold fetch/decode, bubble downstream
//   issued               instruction leaves decode this cycle
// -----------------------------------------------------------------------------
module operand_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int XLEN = 64,
    parameter int NFWD = 3,
    parameter int LW   = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_ra1,
    input  logic [AW-1:0]        iss_ra2,
    input  logic                 iss_use1,
    input  logic                 iss_use2,
    input  logic [AW-1:0]        iss_wa,
    input  logic                 iss_wen,
    input  logic [LW-1:0]        iss_lat,
    input  logic                 flush,
    input  logic [XLEN-1:0]      rd1,
    input  logic [XLEN-1:0]      rd2,
    input  logic [NFWD-1:0]      fwd_en,
    input  logic [NFWD*AW-1:0]   fwd_wa,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_wa,
    output logic [XLEN-1:0]      srca,
    output logic [XLEN-1:0]      srcb,
    output logic                 stall,
    output logic                 issued
);

    // Flattened view of the per-register scoreboard state.
    logic [NREG-1:0] busy_vec;
    logic [LW-1:0]   cnt_arr [NREG];

    // Per-port address match for each source. Register 0 never matches, so
    // a forwarded write to x0 can never leak into an operand.
    logic [NFWD-1:0] hit1_vec;
    logic [NFWD-1:0] hit2_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NFWD; gi++) begin : g_match
            assign hit1_vec[gi] = fwd_en[gi] && (iss_ra1 != '0) &&
                                  (fwd_wa[gi*AW +: AW] == iss_ra1);
            assign hit2_vec[gi] = fwd_en[gi] && (iss_ra2 != '0) &&
                                  (fwd_wa[gi*AW +: AW] == iss_ra2);
        end
    endgenerate

    // Priority select: walk from the oldest port down so the youngest
    // (lowest-index) matching port is the last one written.
    logic            fwd1_hit;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd1_data;
    logic [XLEN-1:0] fwd2_data;

    always_comb begin
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        for (int p = NFWD - 1; p >= 0; p--) begin
            if (hit1_vec[p]) begin
                fwd1_hit  = 1'b1;
                fwd1_data = fwd_data[p*XLEN +: XLEN];
            end
            if (hit2_vec[p]) begin
                fwd2_hit  = 1'b1;
                fwd2_data = fwd_data[p*XLEN +: XLEN];
            end
        end
    end

    // Operand resolution.
    always_comb begin
        srca = rd1;
        srcb = rd2;
        if (iss_ra1 == '0) begin
            srca = '0;
        end else if (fwd1_hit) begin
            srca = fwd1_data;
        end
        if (iss_ra2 == '0) begin
            srcb = '0;
        end else if (fwd2_hit) begin
            srcb = fwd2_data;
        end
    end

    // A source is blocked while its producer is still counting down, or
    // once the count has expired but no forwarding port carries the value
    // (the result is between the last forwarding stage and writeback).
    logic blocked1;
    logic blocked2;
    logic waw;

    assign blocked1 = iss_use1 && (iss_ra1 != '0) && busy_vec[iss_ra1] &&
                      ((cnt_arr[iss_ra1] != '0) || !fwd1_hit);
    assign blocked2 = iss_use2 && (iss_ra2 != '0) && busy_vec[iss_ra2] &&
                      ((cnt_arr[iss_ra2] != '0) || !fwd2_hit);

`ifdef SCOREBOARD_WAW_EN
    // Hold a write that would complete before the older in-flight write to
    // the same register; the older one would otherwise overwrite it.
    assign waw = iss_wen && (iss_wa != '0) && busy_vec[iss_wa] &&
                 (cnt_arr[iss_wa] > iss_lat);
`else
    assign waw = 1'b0;
`endif

    assign stall  = iss_valid && !flush && (blocked1 || blocked2 || waw);
    assign issued = iss_valid && !flush && !stall;

    // Per-register scoreboard entries. Register 0 is tied to not-busy.
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign busy_vec[gi] = 1'b0;
                assign cnt_arr[gi]  = '0;
            end else begin : g_entry
                logic          busy_reg;
                logic          busy_next;
                logic [LW-1:0] cnt_reg;
                logic [LW-1:0] cnt_next;
                logic          set_w;
                logic          clr_w;

                assign set_w = issued && iss_wen && (iss_wa == AW'(gi));
                assign clr_w = wb_valid && (wb_wa == AW'(gi));

                always_comb begin
                    busy_next = busy_reg;
                    cnt_next  = cnt_reg;
                    if (busy_reg && (cnt_reg != '0)) begin
                        cnt_next = cnt_reg - LW'(1);
                    end
                    if (clr_w) begin
                        busy_next = 1'b0;
                    end
                    // A new producer issued in the same cycle as the old
                    // writeback owns the register from now on.
                    if (set_w) begin
                        busy_next = 1'b1;
                        cnt_next  = iss_lat;
                    end
                end

                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        busy_reg <= 1'b0;
                        cnt_reg  <= '0;
                    end else begin
                        busy_reg <= busy_next;
                        cnt_reg  <= cnt_next;
                    end
                end

                assign busy_vec[gi] = busy_reg;
                assign cnt_arr[gi]  = cnt_reg;
            end
        end
    endgenerate

endmodule
